rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
- Upstream stage between the HPS download interface (hps_io ioctl stream) and the williams2 core's ROM write port.
- Filters download bytes by index and buffers them in a 2-entry FIFO with ioctl_wait back-pressure.
- Presents them as a valid/ready write stream to the core's ROM storage, and holds the core in reset until a load completes.
- Reports byte count, 16-bit additive checksum, size mismatch and overflow.

Parameters:
INDEX, 8'd0, ioctl_index value accepted; all other indices are ignored.
ROM_BYTES, 18'd0, expected image size in bytes; 0 disables the size check.
HOLD_CYCLES, 16, clk_sys cycles core_reset stays high after the FIFO drains; must be 1..65535.

Ports:
clk_sys  in  1  system clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
ioctl_download  in  1  download in progress
ioctl_index  in  8  download target index
ioctl_wr  in  1  one-cycle byte strobe
ioctl_addr  in  17  byte address
ioctl_dout  in  8  byte data
ioctl_wait  out  1  back-pressure to hps_io, registered
rom_addr  out  17  FIFO head address
rom_data  out  8  FIFO head data
rom_we  out  1  head valid; write occurs when rom_we and rom_ready
rom_ready  in  1  core ROM port accepts the write this cycle
core_reset  out  1  hold core in reset
load_done  out  1  last load completed
size_err  out  1  byte_count != ROM_BYTES at completion (sticky per load)
ovf_err  out  1  write dropped because FIFO full (sticky per load)
byte_count  out  18  bytes accepted this load
checksum  out  16  mod-2^16 sum of accepted bytes

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - State is IDLE, FIFO is emptied.
  - Outputs: core_reset=1, load_done=0, ioctl_wait=0, rom_we=0, size_err=0, ovf_err=0, byte_count=0, checksum=0, rom_addr=0, rom_data=0.
- sel = ioctl_download && (ioctl_index == INDEX). dl_rise/dl_fall are edges of registered sel.
- Push occurs on ioctl_wr && sel && state==LOAD.
  - Accepted if count<2, or if count==2 and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and ovf_err<=1.
- Pop occurs on rom_we && rom_ready. FIFO order is strictly first-in first-out.
- rom_we = (count != 0). rom_addr/rom_data equal the head entry and stay stable while rom_we && !rom_ready.
- ioctl_wait <= (count_next != 0). Because it is registered, one write may arrive in the cycle ioctl_wait rises; the second slot absorbs it.
- On each accepted push: byte_count += 1 (saturating at 2^18-1); checksum += ioctl_dout (wraps mod 2^16).
- A push into an empty FIFO makes rom_we=1 in the next cycle, i.e. 1-cycle latency from ioctl_wr to rom_we.
- FSM:
  - IDLE: core_reset=1. On dl_rise → LOAD.
  - LOAD: on entry clear byte_count, checksum, size_err, ovf_err; load_done=0, core_reset=1. On dl_fall → DRAIN.
  - DRAIN: no pushes. When count==0 → HOLD; the hold counter is loaded with HOLD_CYCLES.
  - HOLD: decrement each cycle. At 0 → DONE, and in the same edge size_err <= (ROM_BYTES!=0 && byte_count!=ROM_BYTES).
  - DONE: core_reset=0, load_done=1. On dl_rise → LOAD (core_reset=1 and load_done=0 next cycle).
- A dl_rise during DRAIN or HOLD also → LOAD. Any FIFO contents continue to drain; counters clear.
- Downloads with a non-matching index never leave the current state and never touch the FIFO or counters.
- ioctl_addr is passed through unmodified; no address ordering check.
- Reset asserted mid-load or mid-drain: FIFO contents discarded, return to IDLE with core_reset=1. A new download is required.

Test Plan:
- Reset pulse asynchronously mid-cycle → immediately core_reset=1, rom_we=0, ioctl_wait=0, load_done=0, byte_count=0, checksum=0.
- ROM_BYTES=4, HOLD_CYCLES=16, rom_ready=1; download index 0, bytes 01,02,03,04 at addr 0..3 on every 4th cycle:
  - rom_we pulses addr 0..3 in order, each 1 cycle after ioctl_wr.
  - checksum=000A, byte_count=4.
  - core_reset falls 16 cycles after the FIFO empties post-fall; load_done=1, size_err=0.
- rom_ready=0; writes AA@0, BB@1, CC@2 on consecutive cycles:
  - ioctl_wait=1 from cycle after the first write.
  - AA and BB are stored; CC is dropped, ovf_err=1, byte_count=2.
  - Raise rom_ready → AA then BB written; ioctl_wait=0 once empty.
- ROM_BYTES=4; download of 3 bytes index 0 → load_done=1, size_err=1 at completion.
- Download 8 bytes with ioctl_index=1 → no rom_we, byte_count=0, state unchanged (core_reset stays 1 from reset).
- After DONE, start a new index-0 download → core_reset=1 next cycle, counters cleared. Assert reset after 2 bytes → FIFO flushed, rom_we=0, state IDLE. A following complete 4-byte load reaches DONE with checksum of only those 4 bytes.

Source files
------------

// File: rtl/rom_loader.sv
// rom_loader: filters hps_io download bytes by index, buffers them in a 2-entry FIFO
// and replays them as a valid/ready ROM write stream while holding the core in reset.
module rom_loader #(
    parameter logic [7:0]  INDEX       = 8'd0,
    parameter logic [17:0] ROM_BYTES   = 18'd0,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [16:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [16:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        rom_we,
    input  logic        rom_ready,
    output logic        core_reset,
    output logic        load_done,
    output logic        size_err,
    output logic        ovf_err,
    output logic [17:0] byte_count,
    output logic [15:0] checksum
);

    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_HOLD,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } entry_t;

    state_t      state_q;
    logic        sel_q;
    logic [15:0] hold_q;
    logic        core_reset_q;
    logic        load_done_q;
    logic        size_err_q;
    logic        ovf_err_q;
    logic [17:0] byte_count_q;
    logic [15:0] checksum_q;

    entry_t      slot0_q, slot0_d;
    entry_t      slot1_q, slot1_d;
    entry_t      new_entry;
    logic [1:0]  count_q, count_d;
    logic [1:0]  fill;
    logic        ioctl_wait_q;

    logic        sel;
    logic        dl_rise;
    logic        dl_fall;
    logic        push;
    logic        pop;
    logic        accept;
    logic [17:0] byte_count_inc;
    logic        size_mismatch;

    always_comb begin
        sel            = ioctl_download && (ioctl_index == INDEX);
        dl_rise        = sel && !sel_q;
        dl_fall        = !sel && sel_q;
        push           = ioctl_wr && sel && (state_q == S_LOAD);
        pop            = (count_q != 2'd0) && rom_ready;
        accept         = push && ((count_q != 2'd2) || pop);
        byte_count_inc = (byte_count_q == '1) ? byte_count_q : byte_count_q + 18'd1;
        size_mismatch  = (ROM_BYTES != 18'd0) && (byte_count_q != ROM_BYTES);
    end

    // Slot 0 is always the head; a pop shifts slot 1 down before the new byte lands.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        slot0_d        = slot0_q;
        slot1_d        = slot1_q;
        new_entry.addr = ioctl_addr;
        new_entry.data = ioctl_dout;
        fill           = count_q - {1'b0, pop};
        if (pop) begin
            slot0_d = slot1_q;
        end
        if (accept) begin
            if (fill == 2'd0) begin
                slot0_d = new_entry;
            end else begin
                slot1_d = new_entry;
            end
        end
        count_d = fill + {1'b0, accept};
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        // NOTE: the storage slots are reset too, because rom_addr/rom_data must read 0 in reset.
        if (reset) begin
            count_q      <= 2'd0;
            slot0_q      <= '0;
            slot1_q      <= '0;
            ioctl_wait_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            count_q      <= count_d;
            slot0_q      <= slot0_d;
            slot1_q      <= slot1_d;
            ioctl_wait_q <= (count_d != 2'd0);
        end
    end

    // sel_q resets high so a download still active when reset drops is not seen as a new one.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b1;
            hold_q       <= '0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            size_err_q   <= 1'b0;
            ovf_err_q    <= 1'b0;
            byte_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            sel_q <= sel;
            if (accept) begin
                byte_count_q <= byte_count_inc;
                checksum_q   <= checksum_q + {8'h00, ioctl_dout};
            end
            if (push && !accept) begin
                ovf_err_q <= 1'b1;
            end

            if (dl_rise) begin
                state_q      <= S_LOAD;
                core_reset_q <= 1'b1;
                load_done_q  <= 1'b0;
                size_err_q   <= 1'b0;
                ovf_err_q    <= 1'b0;
                byte_count_q <= '0;
                checksum_q   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        core_reset_q <= 1'b1;
                    end
                    S_LOAD: begin
                        if (dl_fall) begin
                            state_q <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (count_q == 2'd0) begin
                            state_q <= S_HOLD;
                            hold_q  <= HOLD_INIT;
                        end
                    end
                    S_HOLD: begin
                        if (hold_q <= 16'd1) begin
                            state_q      <= S_DONE;
                            hold_q       <= '0;
                            core_reset_q <= 1'b0;
                            load_done_q  <= 1'b1;
                            size_err_q   <= size_mismatch;
                        end else begin
                            hold_q <= hold_q - 16'd1;
                        end
                    end
                    S_DONE: begin
                        core_reset_q <= 1'b0;
                        load_done_q  <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign ioctl_wait = ioctl_wait_q;
    assign rom_we     = (count_q != 2'd0);
    assign rom_addr   = slot0_q.addr;
    assign rom_data   = slot0_q.data;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign size_err   = size_err_q;
    assign ovf_err    = ovf_err_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader: directed scenarios plus randomized loads checked
// against a queue-based model of the download stream.
module tb_rom_loader;

    localparam int          HOLD      = 16;
    localparam logic [17:0] ROM_SIZE  = 18'd4;
    // Falling download seen on one edge, empty FIFO seen on the next, then HOLD edges.
    localparam int          DONE_LAT  = HOLD + 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [16:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic        rom_we;
    logic        rom_ready;
    logic        core_reset;
    logic        load_done;
    logic        size_err;
    logic        ovf_err;
    logic [17:0] byte_count;
    logic [15:0] checksum;

    int n_cmp = 0;
    int n_err = 0;

    rom_loader #(
        .INDEX      (8'd0),
        .ROM_BYTES  (ROM_SIZE),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .rom_we        (rom_we),
        .rom_ready     (rom_ready),
        .core_reset    (core_reset),
        .load_done     (load_done),
        .size_err      (size_err),
        .ovf_err       (ovf_err),
        .byte_count    (byte_count),
        .checksum      (checksum)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic write_byte(input logic [16:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic start_download(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
    endtask

    task automatic finish_download(output int edges);
        ioctl_download = 1'b0;
        edges = -1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (load_done === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({core_reset, load_done, rom_we, ioctl_wait, size_err, ovf_err} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {core_reset, load_done, rom_we, ioctl_wait, size_err, ovf_err});
        end
        n_cmp++;
        if ({byte_count, checksum, rom_addr, rom_data} !== 59'd0) begin
            n_err++;
            $display("FAIL reset_values: got cnt=%h sum=%h addr=%h data=%h expected all 0",
                     byte_count, checksum, rom_addr, rom_data);
        end
        reset = 1'b0;
        tick();
        rom_ready = 1'b0;
        start_download(8'd0);
        write_byte(17'h15A5A, 8'h3C);
        tick();
        n_cmp++;
        if ({rom_we, ioctl_wait, byte_count, rom_addr} !== {1'b1, 1'b1, 18'd1, 17'h15A5A}) begin
            n_err++;
            $display("FAIL pre_reset_state: got we=%b wait=%b cnt=%0d addr=%h expected 1 1 1 15a5a",
                     rom_we, ioctl_wait, byte_count, rom_addr);
        end
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({core_reset, load_done, rom_we, ioctl_wait, size_err, ovf_err} !== 6'b100000) begin
            n_err++;
            $display("FAIL async_reset_flags: got %b expected 100000",
                     {core_reset, load_done, rom_we, ioctl_wait, size_err, ovf_err});
        end
        n_cmp++;
        if ({byte_count, checksum, rom_addr, rom_data} !== 59'd0) begin
            n_err++;
            $display("FAIL async_reset_values: got cnt=%h sum=%h addr=%h data=%h expected all 0",
                     byte_count, checksum, rom_addr, rom_data);
        end
        ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_wrong_index();
        rom_ready = 1'b1;
        start_download(8'd1);
        for (int i = 0; i < 8; i++) begin
            write_byte(17'(i), 8'($urandom));
            n_cmp++;
            if ({rom_we, ioctl_wait, core_reset, load_done} !== 4'b0010) begin
                n_err++;
                $display("FAIL wrong_index_flags[%0d]: got %b expected 0010", i,
                         {rom_we, ioctl_wait, core_reset, load_done});
            end
        end
        ioctl_download = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({byte_count, checksum, core_reset} !== {18'd0, 16'd0, 1'b1}) begin
            n_err++;
            $display("FAIL wrong_index_counters: got cnt=%0d sum=%h rst=%b expected 0 0000 1",
                     byte_count, checksum, core_reset);
        end
    endtask

    task automatic test_basic_load();
        int edges;
        rom_ready = 1'b1;
        start_download(8'd0);
        for (int i = 0; i < 4; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = 17'(i);
            ioctl_dout = 8'(i + 1);
            tick();
            ioctl_wr = 1'b0;
            n_cmp++;
            if ({rom_we, rom_addr, rom_data} !== {1'b1, 17'(i), 8'(i + 1)}) begin
                n_err++;
                $display("FAIL basic_head[%0d]: got we=%b addr=%h data=%h expected 1 %h %h",
                         i, rom_we, rom_addr, rom_data, 17'(i), 8'(i + 1));
            end
            tick();
            n_cmp++;
            if (rom_we !== 1'b0) begin
                n_err++;
                $display("FAIL basic_pulse[%0d]: got we=%b expected 0", i, rom_we);
            end
            tick();
            tick();
        end
        n_cmp++;
        if ({byte_count, checksum, core_reset} !== {18'd4, 16'h000A, 1'b1}) begin
            n_err++;
            $display("FAIL basic_counters: got cnt=%0d sum=%h rst=%b expected 4 000a 1",
                     byte_count, checksum, core_reset);
        end
        finish_download(edges);
        n_cmp++;
        if (edges != DONE_LAT) begin
            n_err++;
            $display("FAIL basic_hold_latency: got %0d edges expected %0d", edges, DONE_LAT);
        end
        n_cmp++;
        if ({load_done, core_reset, size_err, ovf_err, byte_count, checksum} !==
            {4'b1000, 18'd4, 16'h000A}) begin
            n_err++;
            $display("FAIL basic_done: got done=%b rst=%b serr=%b ovf=%b cnt=%0d sum=%h expected 1 0 0 0 4 000a",
                     load_done, core_reset, size_err, ovf_err, byte_count, checksum);
        end
    endtask

    task automatic test_overflow();
        int edges;
        rom_ready = 1'b0;
        start_download(8'd0);
        ioctl_wr   = 1'b1;
        ioctl_addr = 17'd0;
        ioctl_dout = 8'hAA;
        tick();
        n_cmp++;
        if (ioctl_wait !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_wait_rise: got %b expected 1", ioctl_wait);
        end
        ioctl_addr = 17'd1;
        ioctl_dout = 8'hBB;
        tick();
        ioctl_addr = 17'd2;
        ioctl_dout = 8'hCC;
        tick();
        ioctl_wr = 1'b0;
        n_cmp++;
        if ({rom_we, ioctl_wait, ovf_err, byte_count, checksum} !== {3'b111, 18'd2, 16'h0165}) begin
            n_err++;
            $display("FAIL ovf_state: got we=%b wait=%b ovf=%b cnt=%0d sum=%h expected 1 1 1 2 0165",
                     rom_we, ioctl_wait, ovf_err, byte_count, checksum);
        end
        tick();
        tick();
        n_cmp++;
        if ({rom_we, rom_addr, rom_data} !== {1'b1, 17'd0, 8'hAA}) begin
            n_err++;
            $display("FAIL ovf_head_stable: got we=%b addr=%h data=%h expected 1 00000 aa",
                     rom_we, rom_addr, rom_data);
        end
        rom_ready = 1'b1;
        tick();
        n_cmp++;
        if ({rom_we, rom_addr, rom_data} !== {1'b1, 17'd1, 8'hBB}) begin
            n_err++;
            $display("FAIL ovf_second: got we=%b addr=%h data=%h expected 1 00001 bb",
                     rom_we, rom_addr, rom_data);
        end
        tick();
        n_cmp++;
        if ({rom_we, ioctl_wait} !== 2'b00) begin
            n_err++;
            $display("FAIL ovf_drained: got we=%b wait=%b expected 0 0", rom_we, ioctl_wait);
        end
        finish_download(edges);
        n_cmp++;
        if ({edges == DONE_LAT, load_done, size_err, ovf_err} !== 4'b1111) begin
            n_err++;
            $display("FAIL ovf_done: got edges=%0d done=%b serr=%b ovf=%b expected %0d 1 1 1",
                     edges, load_done, size_err, ovf_err, DONE_LAT);
        end
    endtask

    task automatic test_short_load();
        int edges;
        rom_ready = 1'b1;
        start_download(8'd0);
        n_cmp++;
        if ({ovf_err, size_err, load_done, byte_count} !== {3'b000, 18'd0}) begin
            n_err++;
            $display("FAIL short_entry_clear: got ovf=%b serr=%b done=%b cnt=%0d expected 0 0 0 0",
                     ovf_err, size_err, load_done, byte_count);
        end
        write_byte(17'd0, 8'h11);
        tick();
        write_byte(17'd1, 8'h22);
        tick();
        write_byte(17'd2, 8'h33);
        tick();
        finish_download(edges);
        n_cmp++;
        if ({edges == DONE_LAT, load_done, size_err, ovf_err, byte_count, checksum} !==
            {4'b1110, 18'd3, 16'h0066}) begin
            n_err++;
            $display("FAIL short_done: got edges=%0d done=%b serr=%b ovf=%b cnt=%0d sum=%h expected %0d 1 1 0 3 0066",
                     edges, load_done, size_err, ovf_err, byte_count, checksum, DONE_LAT);
        end
    endtask

    task automatic test_reload_reset();
        int          edges;
        int          sum;
        logic [7:0]  d;
        n_cmp++;
        if ({load_done, core_reset} !== 2'b10) begin
            n_err++;
            $display("FAIL reload_precond: got done=%b rst=%b expected 1 0", load_done, core_reset);
        end
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        n_cmp++;
        if ({core_reset, load_done, size_err, byte_count, checksum} !== {3'b100, 18'd0, 16'd0}) begin
            n_err++;
            $display("FAIL reload_entry: got rst=%b done=%b serr=%b cnt=%0d sum=%h expected 1 0 0 0 0000",
                     core_reset, load_done, size_err, byte_count, checksum);
        end
        tick();
        rom_ready = 1'b0;
        write_byte(17'd0, 8'h5A);
        write_byte(17'd1, 8'hA5);
        n_cmp++;
        if ({rom_we, byte_count} !== {1'b1, 18'd2}) begin
            n_err++;
            $display("FAIL reload_two_bytes: got we=%b cnt=%0d expected 1 2", rom_we, byte_count);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({core_reset, rom_we, ioctl_wait, byte_count} !== {3'b100, 18'd0}) begin
            n_err++;
            $display("FAIL reload_flush: got rst=%b we=%b wait=%b cnt=%0d expected 1 0 0 0",
                     core_reset, rom_we, ioctl_wait, byte_count);
        end
        tick();
        reset = 1'b0;
        write_byte(17'd2, 8'h77);
        tick();
        tick();
        n_cmp++;
        if ({core_reset, load_done, rom_we, ioctl_wait, byte_count} !== {4'b1000, 18'd0}) begin
            n_err++;
            $display("FAIL reload_idle_after_reset: got rst=%b done=%b we=%b wait=%b cnt=%0d expected 1 0 0 0 0",
                     core_reset, load_done, rom_we, ioctl_wait, byte_count);
        end
        ioctl_download = 1'b0;
        tick();
        tick();
        rom_ready = 1'b1;
        start_download(8'd0);
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            sum += int'(d);
            write_byte(17'(i), d);
            tick();
        end
        finish_download(edges);
        n_cmp++;
        if ({edges == DONE_LAT, load_done, size_err, byte_count, checksum} !==
            {3'b110, 18'd4, 16'(sum)}) begin
            n_err++;
            $display("FAIL reload_final: got edges=%0d done=%b serr=%b cnt=%0d sum=%h expected %0d 1 0 4 %h",
                     edges, load_done, size_err, byte_count, checksum, DONE_LAT, 16'(sum));
        end
    endtask

    task automatic test_random();
        logic [24:0] exp_q[$];
        int          n, written, cyc, sum, edges;
        logic        rdy, wr;
        logic [16:0] a;
        logic [7:0]  d;
        for (int load = 0; load < 4; load++) begin
            exp_q.delete();
            n       = $urandom_range(1, 10);
            written = 0;
            cyc     = 0;
            sum     = 0;
            start_download(8'd0);
            while ((written < n || exp_q.size() != 0) && cyc < 2000) begin
                rdy = ($urandom_range(0, 3) != 0);
                n_cmp++;
                if ({rom_we, ioctl_wait} !== {2{exp_q.size() != 0}}) begin
                    n_err++;
                    $display("FAIL rand_occupancy[%0d]: got we=%b wait=%b expected pending=%0d",
                             load, rom_we, ioctl_wait, exp_q.size());
                end
                if (rom_we === 1'b1 && rdy && exp_q.size() != 0) begin
                    n_cmp++;
                    if ({rom_addr, rom_data} !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL rand_write[%0d]: got addr=%h data=%h expected %h",
                                 load, rom_addr, rom_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                wr = 1'b0;
                if (ioctl_wait === 1'b0 && written < n && $urandom_range(0, 1) == 1) begin
                    a = 17'($urandom);
                    d = 8'($urandom);
                    exp_q.push_back({a, d});
                    sum += int'(d);
                    written++;
                    wr = 1'b1;
                    ioctl_addr = a;
                    ioctl_dout = d;
                end
                ioctl_wr  = wr;
                rom_ready = rdy;
                tick();
                cyc++;
            end
            ioctl_wr  = 1'b0;
            rom_ready = 1'b1;
            n_cmp++;
            if (cyc >= 2000) begin
                n_err++;
                $display("FAIL rand_timeout[%0d]: %0d writes still pending", load, exp_q.size());
            end
            finish_download(edges);
            n_cmp++;
            if ({edges == DONE_LAT, load_done, size_err, byte_count, checksum} !==
                {2'b11, n != 4, 18'(n), 16'(sum)}) begin
                n_err++;
                $display("FAIL rand_done[%0d]: got edges=%0d done=%b serr=%b cnt=%0d sum=%h expected %0d 1 %b %0d %h",
                         load, edges, load_done, size_err, byte_count, checksum,
                         DONE_LAT, n != 4, n, 16'(sum));
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        rom_ready      = 1'b0;
        tick();
        tick();
        tick();
        test_reset();
        test_wrong_index();
        test_basic_load();
        test_overflow();
        test_short_load();
        test_reload_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
